// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the multicycle MIPS core.
// Serves MULT, MULTU, DIV and DIVU with a fixed WIDTH-step loop, then
// writes HI/LO. Signed ops run on magnitudes and are sign-fixed at the end.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, DZ} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder (dividend was negative)
    logic [WIDTH-1:0]   b_mag;      // multiplicand or divisor magnitude
    // Multiply: full shift-add accumulator. Divide: low half shifts the
    // dividend out and the quotient bits in.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes, one loop step, and the final sign correction
    always_comb begin
        op_signed = ~op[0];
        a_mag_in  = (op_signed && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag_in  = (op_signed && b_in[WIDTH-1]) ? -b_in : b_in;
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_mag} : '0);
        div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = (div_shift >= {1'b0, b_mag});
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Sequencer FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_mag    <= '0;
            prod     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        busy   <= 1'b1;
                        if (op[1] && (b_in == '0)) begin
                            // Divide by zero skips the loop entirely
                            state    <= DZ;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            count <= CW'(WIDTH);
                            b_mag <= b_mag_in;
                            prod  <= {{WIDTH{1'b0}}, a_mag_in};
                            rem   <= '0;
                            neg_q <= op_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                            neg_r <= op_signed && a_in[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        rem              <= div_ge ? div_diff : div_shift;
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], div_ge};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    // Sign-corrected result lands in HI/LO on DONE entry
                    state    <= DONE;
                    done     <= 1'b1;
                    hi_write <= 1'b1;
                    lo_write <= 1'b1;
                    if (is_div) begin
                        hi_out <= rem_fix;
                        lo_out <= quo_fix;
                    end else begin
                        hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= prod_fix[WIDTH-1:0];
                    end
                end
                DONE, DZ: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every
// cycle, plus directed literal cases for the documented corner results.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op_i  = 2'd0;
    logic [W-1:0] a_i   = '0;
    logic [W-1:0] b_i   = '0;
    logic         busy, done, div_zero, hi_write, lo_write;
    logic [W-1:0] hi_out, lo_out;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op_i),
        .a_in(a_i), .b_in(b_i),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_write(hi_write), .lo_write(lo_write),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Reference result {div_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model_calc(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'd0: return {1'b0, 64'(sa * sb)};
            2'd1: return {1'b0, ua * ub};
            2'd2: begin
                if (b == 0) return {1'b1, 64'b0};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, 64'b0};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    logic [64:0] calc_now;
    assign calc_now = model_calc(op_i, a_i, b_i);

    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_wr = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;

    // Behavioural model: accept in idle, result appears WIDTH+2 cycles later
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_wr <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0; m_dz <= 1'b0; m_wr <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    if (calc_now[64]) begin
                        m_done <= 1'b1; m_dz <= 1'b1; m_left <= 0;
                    end else begin
                        m_left <= W + 1;
                        p_hi   <= calc_now[63:32];
                        p_lo   <= calc_now[31:0];
                    end
                end
            end else if (m_left == 1) begin
                m_done <= 1'b1; m_wr <= 1'b1; m_hi <= p_hi; m_lo <= p_lo; m_left <= 0;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("div_zero", div_zero, m_dz);
        check("hi_write", hi_write, m_wr);
        check("lo_write", lo_write, m_wr);
        check("hi_out", hi_out, m_hi);
        check("lo_out", lo_out, m_lo);
    endtask

    // Issue one op, optionally re-pulse start mid-run, and check literal results
    task automatic do_lit(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int glitch, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input logic exp_wr);
        int lat;
        @(negedge clk);
        op_i = o; a_i = a; b_i = b; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == glitch);
            a_i = $urandom; b_i = $urandom;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_hi"}, hi_out, exp_hi);
        check({nm, "_lo"}, lo_out, exp_lo);
        check({nm, "_dz"}, div_zero, exp_dz);
        check({nm, "_hiwr"}, hi_write, exp_wr);
        check({nm, "_lowr"}, lo_write, exp_wr);
        check({nm, "_model_hi"}, m_hi, exp_hi);
        check({nm, "_model_lo"}, m_lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_lit("mult_neg", 2'd0, 32'd7, 32'hFFFF_FFFD, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        do_lit("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 34, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b1);
        do_lit("mult_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 34, 32'h0, 32'h1, 1'b0, 1'b1);
        do_lit("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        do_lit("divu", 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 34, 32'h1, 32'h7FFF_FFFC, 1'b0, 1'b1);
        do_lit("div_zero", 2'd2, 32'd5, 32'd0, 0, 1, 32'h1, 32'h7FFF_FFFC, 1'b1, 1'b0);
        @(negedge clk);
        check("dz_busy_after", busy, 1'b0);
        do_lit("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 34, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
        do_lit("glitch", 2'd1, 32'd3, 32'd5, 5, 34, 32'h0, 32'd15, 1'b0, 1'b1);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n++;
        end
        check("glitch_single_done", n, 0);

        // Reset in the middle of a run aborts it without a done pulse
        @(negedge clk);
        op_i = 2'd1; a_i = 32'd9; b_i = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n, 0);
        do_lit("after_abort", 2'd0, 32'd7, 32'hFFFF_FFFD, 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);

        // Random traffic: starts while busy, operand churn, rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom % 3 == 0);
            op_i  = 2'($urandom);
            a_i   = pick();
            b_i   = pick();
            if ($urandom % 500 == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
